jtframe_prog_writer: RTL and testbench

Converts the byte-wide ioctl ROM download stream into SDRAM programming writes (prog_* interface), mapping download offsets onto the four SDRAM banks. It is the writer end of the prog_* handshake whose reader is the frame's SDRAM controller. It sits between the ioctl download port and the SDRAM controller, and buffers bytes while the controller is busy with refresh or game reads.

---
 rtl/jtframe_prog_pkg.sv | 34 +++
 rtl/jtframe_prog_fifo.sv | 40 ++++
 rtl/jtframe_prog_writer.sv | 143 ++++++++++++++
 tb/tb_jtframe_prog_writer.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/jtframe_prog_pkg.sv
// jtframe_prog_pkg: shared types, mask constants and bank decode for the prog_* writer
package jtframe_prog_pkg;

    typedef enum logic [1:0] {IDLE, REQ, WAIT} prog_state_t;

    localparam logic [1:0] MASK_LO = 2'b10;
    localparam logic [1:0] MASK_HI = 2'b01;
    localparam logic [1:0] MASK_W  = 2'b00;

    // a bank spans 8 MiB, so a 22-bit word address covers any in-bank offset
    localparam int PROG_AW = 22;

    typedef struct packed {
        logic [1:0]         ba;
        logic [PROG_AW-1:0] addr;
        logic [15:0]        data;
        logic [1:0]         mask;
    } prog_entry_t;

    function automatic prog_entry_t make_entry(
        input logic [24:0] a,
        input logic [7:0]  d,
        input logic [24:0] b1,
        input logic [24:0] b2,
        input logic [24:0] b3
    );
        logic [1:0]  ba;
        logic [22:0] off;
        ba  = a >= b3 ? 2'd3 : a >= b2 ? 2'd2 : a >= b1 ? 2'd1 : 2'd0;
        off = 23'(a - (ba == 2'd3 ? b3 : ba == 2'd2 ? b2 : ba == 2'd1 ? b1 : 25'd0));
        make_entry = '{ba: ba, addr: off[22:1], data: {2{d}}, mask: off[0] ? MASK_HI : MASK_LO};
    endfunction

endpackage

// File: rtl/jtframe_prog_fifo.sv
// jtframe_prog_fifo: synchronous FIFO, 2**AW entries, push accepted when full only alongside a pop
module jtframe_prog_fifo #(
    parameter int W  = 8,
    parameter int AW = 2
)(
    input  logic         clk,
    input  logic         rst,
    input  logic         push,
    input  logic         pop,
    input  logic [W-1:0] din,
    output logic [W-1:0] dout,
    output logic         full,
    output logic         empty
);
    logic [W-1:0]  mem [2**AW];
    logic [AW-1:0] wp, rp;
    logic [AW:0]   cnt;
    logic          wr, rd;

    assign full  = cnt == (AW+1)'(2**AW);
    assign empty = cnt == '0;
    assign rd    = pop & ~empty;
    assign wr    = push & (~full | rd);
    assign dout  = mem[rp];

    always_ff @(posedge clk)
        if (wr) mem[wp] <= din;

    always_ff @(posedge clk) begin
        if (rst) begin
            wp  <= '0;
            rp  <= '0;
            cnt <= '0;
        end else begin
            wp  <= wp + AW'(wr);
            rp  <= rp + AW'(rd);
            cnt <= cnt + (AW+1)'(wr) - (AW+1)'(rd);
        end
    end
endmodule

// File: rtl/jtframe_prog_writer.sv
// jtframe_prog_writer: turns the ioctl byte stream into banked SDRAM prog_* writes through a FIFO
// Define JTFRAME_PROG_PAIR_EN to merge even/odd byte pairs into single 16-bit writes.
module jtframe_prog_writer
    import jtframe_prog_pkg::*;
#(
    parameter int          SDRAMW    = 22,
    parameter logic [24:0] BA1_START = 25'h080_0000,
    parameter logic [24:0] BA2_START = 25'h100_0000,
    parameter logic [24:0] BA3_START = 25'h180_0000,
    parameter int          FIFO_AW   = 2
)(
    input  logic              clk,
    input  logic              rst,
    input  logic              downloading,
    input  logic [24:0]       ioctl_addr,
    input  logic [7:0]        ioctl_data,
    input  logic              ioctl_wr,
    output logic [SDRAMW-1:0] prog_addr,
    output logic [15:0]       prog_data,
    output logic [1:0]        prog_mask,
    output logic [1:0]        prog_ba,
    output logic              prog_we,
    input  logic              prog_ack,
    input  logic              prog_rdy,
    output logic              dwnld_busy,
    output logic              ovf
);
    prog_state_t st, st_nx;
    prog_entry_t new_e, nx_tr, tr, fifo_q;
    logic        nx_valid, tr_valid, dl_d, full, empty, pop, drop, hold_busy;

    assign new_e = make_entry(ioctl_addr, ioctl_data, BA1_START, BA2_START, BA3_START);

`ifdef JTFRAME_PROG_PAIR_EN
    prog_entry_t held, held_nx;
    logic        held_v, held_nx_v, merge, dl_fall;

    assign dl_fall   = dl_d & ~downloading;
    assign hold_busy = held_v;
    assign merge     = held_v && held.mask == MASK_LO && new_e.mask == MASK_HI &&
                       new_e.ba == held.ba && new_e.addr == held.addr;

    // one entry leaves per cycle; an odd byte that could not be emitted waits here a cycle
    always_comb begin
        nx_valid  = 1'b0;
        nx_tr     = new_e;
        held_nx   = held;
        held_nx_v = held_v;
        if (ioctl_wr) begin
            if (merge) begin
                nx_valid  = 1'b1;
                nx_tr     = '{ba: held.ba, addr: held.addr, data: {new_e.data[15:8], held.data[7:0]}, mask: MASK_W};
                held_nx_v = 1'b0;
            end else if (held_v) begin
                nx_valid = 1'b1;
                nx_tr    = held;
                held_nx  = new_e;
            end else if (new_e.mask == MASK_LO) begin
                held_nx   = new_e;
                held_nx_v = 1'b1;
            end else begin
                nx_valid = 1'b1;
            end
        end else if (held_v && (held.mask == MASK_HI || dl_fall)) begin
            nx_valid  = 1'b1;
            nx_tr     = held;
            held_nx_v = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            held_v <= 1'b0;
            held   <= '0;
        end else begin
            held_v <= held_nx_v;
            held   <= held_nx;
        end
    end
`else
    assign nx_valid  = ioctl_wr;
    assign nx_tr     = new_e;
    assign hold_busy = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            tr_valid <= 1'b0;
            tr       <= '0;
        end else begin
            tr_valid <= nx_valid;
            tr       <= nx_tr;
        end
    end

    jtframe_prog_fifo #(.W($bits(prog_entry_t)), .AW(FIFO_AW)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (tr_valid),
        .pop   (pop),
        .din   (tr),
        .dout  (fifo_q),
        .full  (full),
        .empty (empty)
    );

    assign pop        = st == IDLE && !empty;
    assign drop       = tr_valid & full & ~pop;
    assign prog_we    = st == REQ;
    assign dwnld_busy = downloading | tr_valid | ~empty | (st != IDLE) | hold_busy;

    always_comb begin
        st_nx = st;
        unique case (st)
            IDLE:    st_nx = empty ? IDLE : REQ;
            REQ:     st_nx = prog_ack ? (prog_rdy ? IDLE : WAIT) : REQ;
            WAIT:    st_nx = prog_rdy ? IDLE : WAIT;
            default: st_nx = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            st        <= IDLE;
            prog_addr <= '0;
            prog_data <= '0;
            prog_mask <= 2'b11;
            prog_ba   <= '0;
            ovf       <= 1'b0;
            dl_d      <= 1'b0;
        end else begin
            st   <= st_nx;
            dl_d <= downloading;
            ovf  <= (ovf & ~(downloading & ~dl_d)) | drop;
            if (pop) begin
                prog_addr <= SDRAMW'(fifo_q.addr);
                prog_data <= fifo_q.data;
                prog_mask <= fifo_q.mask;
                prog_ba   <= fifo_q.ba;
            end
        end
    end
endmodule

// File: tb/tb_jtframe_prog_writer.sv
// tb_jtframe_prog_writer: directed self-checking bench for jtframe_prog_writer
module tb_jtframe_prog_writer;
    logic        clk = 1'b0, rst = 1'b1, downloading = 1'b0, ioctl_wr = 1'b0;
    logic        prog_ack = 1'b0, prog_rdy = 1'b0;
    logic [24:0] ioctl_addr = '0;
    logic [7:0]  ioctl_data = '0;
    logic [21:0] prog_addr;
    logic [15:0] prog_data;
    logic [1:0]  prog_mask, prog_ba;
    logic        prog_we, dwnld_busy, ovf;
    int          n_cmp = 0, n_bad = 0;

    localparam logic [24:0] TA [5] = '{25'h100_0004, 25'h07F_FFFF, 25'h080_0002, 25'h180_0001, 25'h0FF_FFFF};
    localparam logic [1:0]  TB [5] = '{2'd2, 2'd0, 2'd1, 2'd3, 2'd1};
    localparam logic [21:0] TW [5] = '{22'h2, 22'h3F_FFFF, 22'h1, 22'h0, 22'h3F_FFFF};
    localparam logic [1:0]  TM [5] = '{2'b10, 2'b01, 2'b10, 2'b01, 2'b01};

    always #5 clk = ~clk;

    jtframe_prog_writer dut (
        .clk(clk), .rst(rst), .downloading(downloading),
        .ioctl_addr(ioctl_addr), .ioctl_data(ioctl_data), .ioctl_wr(ioctl_wr),
        .prog_addr(prog_addr), .prog_data(prog_data), .prog_mask(prog_mask), .prog_ba(prog_ba),
        .prog_we(prog_we), .prog_ack(prog_ack), .prog_rdy(prog_rdy),
        .dwnld_busy(dwnld_busy), .ovf(ovf)
    );

    task automatic put_byte(input logic [24:0] a, input logic [7:0] d);
        @(negedge clk);
        ioctl_addr = a;
        ioctl_data = d;
        ioctl_wr   = 1'b1;
        @(negedge clk);
        ioctl_wr = 1'b0;
    endtask

    task automatic wait_we(output int lat);
        lat = 0;
        while (prog_we !== 1'b1 && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    task automatic finish_write(input bit same);
        prog_ack = 1'b1;
        prog_rdy = same;
        @(negedge clk);
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        if (!same) begin
            @(negedge clk);
            prog_rdy = 1'b1;
            @(negedge clk);
            prog_rdy = 1'b0;
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0) begin n_bad++; $display("FAIL reset_we: got %b want 0", prog_we); end
        n_cmp++; if (prog_mask !== 2'b11) begin n_bad++; $display("FAIL reset_mask: got %b want 11", prog_mask); end
        n_cmp++; if (prog_addr !== 22'd0) begin n_bad++; $display("FAIL reset_addr: got %h want 0", prog_addr); end
        n_cmp++; if (prog_data !== 16'd0) begin n_bad++; $display("FAIL reset_data: got %h want 0", prog_data); end
        n_cmp++; if (prog_ba !== 2'd0) begin n_bad++; $display("FAIL reset_ba: got %0d want 0", prog_ba); end
        n_cmp++; if (dwnld_busy !== 1'b0) begin n_bad++; $display("FAIL reset_busy: got %b want 0", dwnld_busy); end
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL reset_ovf: got %b want 0", ovf); end
    endtask

    task automatic test_single;
        int lat;
        downloading = 1'b1;
        put_byte(25'h000_0003, 8'hA5);
        wait_we(lat);
        n_cmp++; if (lat + 1 !== 3) begin n_bad++; $display("FAIL single_latency: got %0d want 3", lat + 1); end
        n_cmp++; if (prog_ba !== 2'd0) begin n_bad++; $display("FAIL single_ba: got %0d want 0", prog_ba); end
        n_cmp++; if (prog_addr !== 22'd1) begin n_bad++; $display("FAIL single_addr: got %h want 1", prog_addr); end
        n_cmp++; if (prog_data !== 16'hA5A5) begin n_bad++; $display("FAIL single_data: got %h want a5a5", prog_data); end
        n_cmp++; if (prog_mask !== 2'b01) begin n_bad++; $display("FAIL single_mask: got %b want 01", prog_mask); end
        repeat (2) @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1 || prog_addr !== 22'd1) begin n_bad++; $display("FAIL single_hold: got we=%b addr=%h want we=1 addr=1", prog_we, prog_addr); end
        downloading = 1'b0;
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        n_cmp++; if (prog_we !== 1'b0) begin n_bad++; $display("FAIL single_we_drop: got %b want 0", prog_we); end
        n_cmp++; if (dwnld_busy !== 1'b1) begin n_bad++; $display("FAIL single_busy_wait: got %b want 1", dwnld_busy); end
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
        n_cmp++; if (dwnld_busy !== 1'b0) begin n_bad++; $display("FAIL single_busy_fall: got %b want 0", dwnld_busy); end
    endtask

    task automatic test_banks;
        int lat;
        downloading = 1'b1;
        for (int i = 0; i < 5; i++) begin
            put_byte(TA[i], 8'h40 + 8'(i));
            wait_we(lat);
            n_cmp++; if (prog_ba !== TB[i]) begin n_bad++; $display("FAIL bank_ba[%0d]: got %0d want %0d", i, prog_ba, TB[i]); end
            n_cmp++; if (prog_addr !== TW[i]) begin n_bad++; $display("FAIL bank_addr[%0d]: got %h want %h", i, prog_addr, TW[i]); end
            n_cmp++; if (prog_mask !== TM[i]) begin n_bad++; $display("FAIL bank_mask[%0d]: got %b want %b", i, prog_mask, TM[i]); end
            n_cmp++; if (prog_data !== {2{8'h40 + 8'(i)}}) begin n_bad++; $display("FAIL bank_data[%0d]: got %h want %h", i, prog_data, {2{8'h40 + 8'(i)}}); end
            finish_write(1'b1);
            @(negedge clk);
        end
    endtask

    task automatic test_overflow;
        int lat, cnt;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            ioctl_addr = 25'h10 + 25'(i);
            ioctl_data = 8'h60 + 8'(i);
            ioctl_wr   = 1'b1;
        end
        @(negedge clk);
        ioctl_wr = 1'b0;
        repeat (20) @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_set: got %b want 1", ovf); end
        for (int j = 0; j < 5; j++) begin
            wait_we(lat);
            n_cmp++; if (prog_we !== 1'b1 || prog_data !== {2{8'h60 + 8'(j)}}) begin n_bad++; $display("FAIL ovf_data[%0d]: got we=%b data=%h want we=1 data=%h", j, prog_we, prog_data, {2{8'h60 + 8'(j)}}); end
            n_cmp++; if (prog_addr !== 22'((25'h10 + 25'(j)) >> 1)) begin n_bad++; $display("FAIL ovf_addr[%0d]: got %h want %h", j, prog_addr, 22'((25'h10 + 25'(j)) >> 1)); end
            finish_write(1'b0);
        end
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (prog_we) cnt++;
        end
        n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL ovf_dropped: got %0d extra cycles of prog_we want 0", cnt); end
        downloading = 1'b0;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky: got %b want 1", ovf); end
        downloading = 1'b1;
        @(negedge clk);
        n_cmp++; if (ovf !== 1'b0) begin n_bad++; $display("FAIL ovf_clear: got %b want 0", ovf); end
    endtask

    task automatic test_back_to_back;
        int lat;
        put_byte(25'h20, 8'h71);
        put_byte(25'h21, 8'h72);
        put_byte(25'h22, 8'h73);
        wait_we(lat);
        repeat (6) @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1 || prog_data !== 16'h7171) begin n_bad++; $display("FAIL b2b_first: got we=%b data=%h want we=1 data=7171", prog_we, prog_data); end
        prog_ack = 1'b1;
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        prog_rdy = 1'b0;
        n_cmp++; if (prog_we !== 1'b0) begin n_bad++; $display("FAIL b2b_gap1: got %b want 0", prog_we); end
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1 || prog_data !== 16'h7272) begin n_bad++; $display("FAIL b2b_second: got we=%b data=%h want we=1 data=7272", prog_we, prog_data); end
        prog_ack = 1'b1;
        @(negedge clk);
        prog_ack = 1'b0;
        prog_rdy = 1'b1;
        @(negedge clk);
        prog_rdy = 1'b0;
        n_cmp++; if (prog_we !== 1'b0) begin n_bad++; $display("FAIL b2b_gap2: got %b want 0", prog_we); end
        @(negedge clk);
        n_cmp++; if (prog_we !== 1'b1 || prog_data !== 16'h7373 || prog_mask !== 2'b10) begin n_bad++; $display("FAIL b2b_third: got we=%b data=%h mask=%b want we=1 data=7373 mask=10", prog_we, prog_data, prog_mask); end
        finish_write(1'b1);
        @(negedge clk);
    endtask

    task automatic test_reset_mid;
        int lat, cnt;
        downloading = 1'b0;
        put_byte(25'h30, 8'h81);
        put_byte(25'h31, 8'h82);
        wait_we(lat);
        n_cmp++; if (prog_we !== 1'b1) begin n_bad++; $display("FAIL rstmid_req: got %b want 1", prog_we); end
        repeat (2) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        n_cmp++; if (prog_we !== 1'b0) begin n_bad++; $display("FAIL rstmid_we: got %b want 0", prog_we); end
        n_cmp++; if (dwnld_busy !== 1'b0) begin n_bad++; $display("FAIL rstmid_busy: got %b want 0", dwnld_busy); end
        n_cmp++; if (prog_mask !== 2'b11) begin n_bad++; $display("FAIL rstmid_mask: got %b want 11", prog_mask); end
        cnt = 0;
        repeat (10) begin
            @(negedge clk);
            if (prog_we) cnt++;
        end
        n_cmp++; if (cnt !== 0) begin n_bad++; $display("FAIL rstmid_flush: got %0d cycles of prog_we want 0", cnt); end
    endtask

`ifdef JTFRAME_PROG_PAIR_EN
    task automatic test_pair;
        int lat;
        downloading = 1'b1;
        put_byte(25'h0, 8'h12);
        put_byte(25'h1, 8'h34);
        wait_we(lat);
        n_cmp++; if (prog_data !== 16'h3412) begin n_bad++; $display("FAIL pair_data: got %h want 3412", prog_data); end
        n_cmp++; if (prog_mask !== 2'b00) begin n_bad++; $display("FAIL pair_mask: got %b want 00", prog_mask); end
        n_cmp++; if (prog_addr !== 22'd0) begin n_bad++; $display("FAIL pair_addr: got %h want 0", prog_addr); end
        finish_write(1'b1);
        @(negedge clk);
        put_byte(25'h2, 8'h56);
        repeat (5) @(negedge clk);
        n_cmp++; if (prog_we !== 1'b0 || dwnld_busy !== 1'b1) begin n_bad++; $display("FAIL pair_held: got we=%b busy=%b want we=0 busy=1", prog_we, dwnld_busy); end
        downloading = 1'b0;
        wait_we(lat);
        n_cmp++; if (prog_data[7:0] !== 8'h56) begin n_bad++; $display("FAIL pair_flush_data: got %h want 56", prog_data[7:0]); end
        n_cmp++; if (prog_mask !== 2'b10) begin n_bad++; $display("FAIL pair_flush_mask: got %b want 10", prog_mask); end
        n_cmp++; if (prog_addr !== 22'd1) begin n_bad++; $display("FAIL pair_flush_addr: got %h want 1", prog_addr); end
        finish_write(1'b1);
    endtask
`endif

    initial begin
        test_reset;
`ifdef JTFRAME_PROG_PAIR_EN
        test_pair;
`else
        test_single;
        test_banks;
        test_overflow;
        test_back_to_back;
        test_reset_mid;
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
